// File: rtl/audio_adc_rx_if.sv
// Consumer-side handshake bundle for audio_adc_rx: held stereo pair, valid/ready, overrun flag.
// The master modport is the receiver; the slave modport is the user logic consuming pairs.
interface audio_adc_rx_if #(
    parameter int unsigned DATA_W = 16
);
    logic              iREADY;
    logic [DATA_W-1:0] oLEFT;
    logic [DATA_W-1:0] oRIGHT;
    logic              oVALID;
    logic              oOVERRUN;

    modport master (
        input  iREADY,
        output oLEFT,
        output oRIGHT,
        output oVALID,
        output oOVERRUN
    );

    modport slave (
        output iREADY,
        input  oLEFT,
        input  oRIGHT,
        input  oVALID,
        input  oOVERRUN
    );
endinterface

// File: rtl/audio_adc_rx.sv
// I2S ADC receiver: synchronizes BCK/LRCK/DAT, deserializes left/right slots, holds each pair
// behind a valid/ready register. Define ADC_RX_MONO_EN to output (L+R)>>>1 on both channels.
module audio_adc_rx #(
    parameter int unsigned DATA_W = 16
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic                  iAUD_BCK,
    input  logic                  iAUD_LRCK,
    input  logic                  iAUD_ADCDAT,
    audio_adc_rx_if.master        rx
);
    localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

    typedef enum logic [1:0] {StIdle, StSkip, StShift, StWait} state_e;

    logic bck_s1_q, bck_s2_q, bck_s3_q;
    logic lrck_s1_q, lrck_s2_q, lrck_s3_q, lrck_s3_d;
    logic dat_s1_q, dat_s2_q;

    state_e            state_q, state_d;
    logic              chan_q, chan_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] left_q, left_d;
    logic [DATA_W-1:0] right_q, right_d;
    logic              left_ok_q, left_ok_d;
    logic              pair_q, pair_d;
    logic [DATA_W-1:0] out_left_q, out_left_d;
    logic [DATA_W-1:0] out_right_q, out_right_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;

    logic              bit_evt, lr_edge;
    logic [DATA_W-1:0] shift_nxt, load_left, load_right;

    // lrck_s3 is sampled only on bit events, so an LRCK edge is judged at BCK rises.
    assign bit_evt   = bck_s2_q & ~bck_s3_q;
    assign lr_edge   = bit_evt & (lrck_s2_q ^ lrck_s3_q);
    assign shift_nxt = {shift_q[DATA_W-2:0], dat_s2_q};

`ifdef ADC_RX_MONO_EN
    logic [DATA_W:0] mono_sum;
    assign mono_sum   = {left_q[DATA_W-1], left_q} + {right_q[DATA_W-1], right_q};
    assign load_left  = mono_sum[DATA_W:1];
    assign load_right = mono_sum[DATA_W:1];
`else
    assign load_left  = left_q;
    assign load_right = right_q;
`endif

    always_comb begin
        lrck_s3_d = lrck_s3_q;
        state_d   = state_q;
        chan_d    = chan_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        left_d    = left_q;
        right_d   = right_q;
        left_ok_d = left_ok_q;
        pair_d    = 1'b0;
        if (bit_evt) begin
            lrck_s3_d = lrck_s2_q;
            // The edge-detecting rise carries the I2S delay bit; the MSB arrives next rise.
            if (lr_edge && (state_q != StIdle || !lrck_s2_q)) begin
                state_d = StSkip;
                chan_d  = lrck_s2_q;
                cnt_d   = '0;
                shift_d = '0;
                if (!lrck_s2_q) left_ok_d = 1'b0;
            end else begin
                unique case (state_q)
                    StSkip: begin
                        shift_d = shift_nxt;
                        cnt_d   = CntW'(1);
                        state_d = StShift;
                    end
                    StShift: begin
                        shift_d = shift_nxt;
                        if (cnt_q == LastBit) begin
                            state_d = StWait;
                            cnt_d   = '0;
                            if (!chan_q) begin
                                left_d    = shift_nxt;
                                left_ok_d = 1'b1;
                            end else if (left_ok_q) begin
                                right_d   = shift_nxt;
                                pair_d    = 1'b1;
                                left_ok_d = 1'b0;
                            end
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        out_left_d  = out_left_q;
        out_right_d = out_right_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        if (pair_q) begin
            if (!valid_q || rx.iREADY) begin
                out_left_d  = load_left;
                out_right_d = load_right;
                valid_d     = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && rx.iREADY) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            bck_s1_q    <= 1'b0;
            bck_s2_q    <= 1'b0;
            bck_s3_q    <= 1'b0;
            lrck_s1_q   <= 1'b0;
            lrck_s2_q   <= 1'b0;
            lrck_s3_q   <= 1'b0;
            dat_s1_q    <= 1'b0;
            dat_s2_q    <= 1'b0;
            state_q     <= StIdle;
            chan_q      <= 1'b0;
            cnt_q       <= '0;
            shift_q     <= '0;
            left_q      <= '0;
            right_q     <= '0;
            left_ok_q   <= 1'b0;
            pair_q      <= 1'b0;
            out_left_q  <= '0;
            out_right_q <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            bck_s1_q    <= iAUD_BCK;
            bck_s2_q    <= bck_s1_q;
            bck_s3_q    <= bck_s2_q;
            lrck_s1_q   <= iAUD_LRCK;
            lrck_s2_q   <= lrck_s1_q;
            lrck_s3_q   <= lrck_s3_d;
            dat_s1_q    <= iAUD_ADCDAT;
            dat_s2_q    <= dat_s1_q;
            state_q     <= state_d;
            chan_q      <= chan_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            left_q      <= left_d;
            right_q     <= right_d;
            left_ok_q   <= left_ok_d;
            pair_q      <= pair_d;
            out_left_q  <= out_left_d;
            out_right_q <= out_right_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx.oLEFT    = out_left_q;
    assign rx.oRIGHT   = out_right_q;
    assign rx.oVALID   = valid_q;
    assign rx.oOVERRUN = overrun_q;
endmodule

// File: tb/tb_audio_adc_rx.sv
// Bench for audio_adc_rx: builds I2S slot streams, predicts received pairs from slot lengths
// and values, and checks the handshake, overrun, reset and (optionally) mono behaviour.
module tb_audio_adc_rx;
    localparam int unsigned DATA_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bck = 1'b0;
    logic lrck = 1'b0;
    logic dat = 1'b0;

    always #5 clk = ~clk;

    audio_adc_rx_if #(.DATA_W(DATA_W)) rx_if ();

    audio_adc_rx #(.DATA_W(DATA_W)) dut (
        .iCLK       (clk),
        .iRST_N     (rst_n),
        .iAUD_BCK   (bck),
        .iAUD_LRCK  (lrck),
        .iAUD_ADCDAT(dat),
        .rx         (rx_if)
    );

    int checks = 0;
    int errors = 0;
    int xfers = 0;
    bit auto_chk = 1'b0;

    bit          sl_ch[$];
    int          sl_len[$];
    logic [15:0] sl_val[$];
    bit          lr_q[$];
    bit          d_q[$];
    logic [15:0] exp_l[$];
    logic [15:0] exp_r[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected output pair {left, right} for a received L/R.
    function automatic logic [31:0] fmt(input logic [15:0] l, input logic [15:0] r);
`ifdef ADC_RX_MONO_EN
        int s;
        s = int'($signed(l)) + int'($signed(r));
        s = s >>> 1;
        return {s[15:0], s[15:0]};
`else
        return {l, r};
`endif
    endfunction

    task automatic clear_stream();
        sl_ch.delete(); sl_len.delete(); sl_val.delete();
        lr_q.delete(); d_q.delete(); exp_l.delete(); exp_r.delete();
    endtask

    // One slot = len BCK periods; period 0 is the I2S delay bit, then MSB-first data, then junk.
    task automatic add_slot(input bit ch, input int len, input logic [15:0] v);
        sl_ch.push_back(ch); sl_len.push_back(len); sl_val.push_back(v);
        for (int k = 0; k < len; k++) begin
            lr_q.push_back(ch);
            if (k >= 1 && k <= DATA_W) d_q.push_back(v[DATA_W-k]);
            else d_q.push_back(1'($urandom_range(0, 1)));
        end
    endtask

    // The first slot starts before reset release, so it never counts.
    task automatic model_stream();
        bit lok = 1'b0;
        logic [15:0] lv = '0;
        logic [31:0] p;
        for (int i = 1; i < sl_ch.size(); i++) begin
            bit full = (sl_len[i] >= DATA_W + 1);
            if (!sl_ch[i]) begin
                lok = full;
                lv  = sl_val[i];
            end else if (full && lok) begin
                p = fmt(lv, sl_val[i]);
                exp_l.push_back(p[31:16]);
                exp_r.push_back(p[15:0]);
                lok = 1'b0;
            end
        end
    endtask

    task automatic accept_check();
        logic [31:0] po, pn;
        po = fmt(16'd5, 16'd6);
        pn = fmt(16'd7, 16'd8);
        repeat (3) @(posedge clk);
        #1 rx_if.iREADY = 1'b1;
        @(negedge clk);
        check_val("acc_old_valid", 32'(rx_if.oVALID), 32'd1);
        check_val("acc_old_left", 32'(rx_if.oLEFT), 32'(po[31:16]));
        check_val("acc_old_right", 32'(rx_if.oRIGHT), 32'(po[15:0]));
        @(posedge clk);
        #1 rx_if.iREADY = 1'b0;
        check_val("acc_new_valid", 32'(rx_if.oVALID), 32'd1);
        check_val("acc_new_left", 32'(rx_if.oLEFT), 32'(pn[31:16]));
        check_val("acc_new_right", 32'(rx_if.oRIGHT), 32'(pn[15:0]));
        check_val("acc_overrun", 32'(rx_if.oOVERRUN), 32'd0);
        repeat (3) @(posedge clk);
    endtask

    task automatic drive_stream(input int mark);
        for (int p = 0; p < lr_q.size(); p++) begin
            @(posedge clk);
            #1 bck = 1'b0; lrck = lr_q[p]; dat = d_q[p];
            repeat (8) @(posedge clk);
            #1 bck = 1'b1;
            if (p == mark) accept_check();
            else repeat (7) @(posedge clk);
        end
        repeat (20) @(posedge clk);
    endtask

    task automatic do_reset(input bit lv);
        #1 rst_n = 1'b0; bck = 1'b0; lrck = lv; dat = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic check_auto_end(input string tag, input int base, input int want);
        check_val({tag, "_xfers"}, 32'(xfers - base), 32'(want));
        check_val({tag, "_left_over"}, 32'(exp_l.size()), 32'd0);
        check_val({tag, "_overrun"}, 32'(rx_if.oOVERRUN), 32'd0);
    endtask

    always @(negedge clk) begin
        if (auto_chk && rx_if.oVALID && rx_if.iREADY) begin
            xfers++;
            if (exp_l.size() == 0) begin
                check_val("unexpected_pair", 32'(exp_l.size()), 32'd1);
            end else begin
                check_val("pair_left", 32'(rx_if.oLEFT), 32'(exp_l.pop_front()));
                check_val("pair_right", 32'(rx_if.oRIGHT), 32'(exp_r.pop_front()));
            end
        end
    end

    initial begin : main
        int base, want;
        int lens[5];
        logic [31:0] p;
        lens = '{32, 24, 17, 16, 11};
        rx_if.iREADY = 1'b0;

        // Reset values, then three identical frames streamed from mid right slot.
        #1 rst_n = 1'b0; lrck = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_valid", 32'(rx_if.oVALID), 32'd0);
        check_val("rst_left", 32'(rx_if.oLEFT), 32'd0);
        check_val("rst_right", 32'(rx_if.oRIGHT), 32'd0);
        check_val("rst_overrun", 32'(rx_if.oOVERRUN), 32'd0);
        do_reset(1'b1);
        clear_stream();
        rx_if.iREADY = 1'b1;
        auto_chk = 1'b1;
        add_slot(1'b1, 20, 16'hFFFF);
        for (int i = 0; i < 3; i++) begin
            add_slot(1'b0, 32, 16'h1234);
            add_slot(1'b1, 32, 16'hA5C3);
        end
        model_stream();
        base = xfers;
        drive_stream(-1);
        check_auto_end("frames3", base, 3);

        // Partial left, then a stray right before the first full left.
        do_reset(1'b0);
        clear_stream();
        add_slot(1'b0, 12, 16'h0F0F);
        add_slot(1'b1, 32, 16'hBEEF);
        for (int i = 0; i < 2; i++) begin
            add_slot(1'b0, 32, 16'($urandom));
            add_slot(1'b1, 32, 16'($urandom));
        end
        model_stream();
        want = exp_l.size();
        base = xfers;
        drive_stream(-1);
        check_auto_end("stray", base, want);

        // Random values and slot lengths, a short left slot, and the mono corner values.
        do_reset(1'b1);
        clear_stream();
        add_slot(1'b1, 32, 16'h0);
        add_slot(1'b0, 11, 16'h5555);
        add_slot(1'b1, 32, 16'h6666);
        add_slot(1'b0, 32, 16'h7FFF);
        add_slot(1'b1, 32, 16'h7FFF);
        add_slot(1'b0, 17, 16'h8000);
        add_slot(1'b1, 17, 16'h0001);
        for (int i = 0; i < 8; i++) begin
            add_slot(1'b0, lens[$urandom_range(0, 4)], 16'($urandom));
            add_slot(1'b1, lens[$urandom_range(0, 4)], 16'($urandom));
        end
        add_slot(1'b0, 32, 16'h0123);
        add_slot(1'b1, 32, 16'hFEDC);
        model_stream();
        want = exp_l.size();
        base = xfers;
        drive_stream(-1);
        check_auto_end("random", base, want);
        auto_chk = 1'b0;

        // Overrun: consumer stalls for two frames.
        do_reset(1'b1);
        clear_stream();
        rx_if.iREADY = 1'b0;
        add_slot(1'b1, 32, 16'h0);
        add_slot(1'b0, 32, 16'd1); add_slot(1'b1, 32, 16'd2);
        add_slot(1'b0, 32, 16'd3); add_slot(1'b1, 32, 16'd4);
        drive_stream(-1);
        p = fmt(16'd1, 16'd2);
        check_val("ovr_valid", 32'(rx_if.oVALID), 32'd1);
        check_val("ovr_left", 32'(rx_if.oLEFT), 32'(p[31:16]));
        check_val("ovr_right", 32'(rx_if.oRIGHT), 32'(p[15:0]));
        check_val("ovr_flag", 32'(rx_if.oOVERRUN), 32'd1);
        #1 rx_if.iREADY = 1'b1;
        @(posedge clk);
        #1 rx_if.iREADY = 1'b0;
        check_val("ovr_drained", 32'(rx_if.oVALID), 32'd0);
        check_val("ovr_keep_left", 32'(rx_if.oLEFT), 32'(p[31:16]));
        repeat (10) @(posedge clk);
        check_val("ovr_sticky", 32'(rx_if.oOVERRUN), 32'd1);
        do_reset(1'b1);
        check_val("ovr_cleared", 32'(rx_if.oOVERRUN), 32'd0);

        // Accept exactly on the cycle the next pair loads.
        clear_stream();
        add_slot(1'b1, 32, 16'h0);
        add_slot(1'b0, 32, 16'd5); add_slot(1'b1, 32, 16'd6);
        add_slot(1'b0, 32, 16'd7); add_slot(1'b1, 32, 16'd8);
        drive_stream(128 + DATA_W);
        check_val("acc_end_overrun", 32'(rx_if.oOVERRUN), 32'd0);

        // Asynchronous reset mid left slot; only the next fresh frame may come through.
        do_reset(1'b1);
        clear_stream();
        add_slot(1'b1, 32, 16'h0);
        add_slot(1'b0, 32, 16'd1); add_slot(1'b1, 32, 16'd2);
        add_slot(1'b0, 32, 16'd3); add_slot(1'b1, 32, 16'd4);
        add_slot(1'b0, 32, 16'd9); add_slot(1'b1, 32, 16'd10);
        fork
            drive_stream(-1);
            begin
                repeat (106 * 16) @(posedge clk);
                check_val("mid_pre_valid", 32'(rx_if.oVALID), 32'd1);
                #3 rst_n = 1'b0;
                #1;
                check_val("mid_valid", 32'(rx_if.oVALID), 32'd0);
                check_val("mid_left", 32'(rx_if.oLEFT), 32'd0);
                check_val("mid_right", 32'(rx_if.oRIGHT), 32'd0);
                check_val("mid_overrun", 32'(rx_if.oOVERRUN), 32'd0);
                #20 rst_n = 1'b1;
            end
        join
        p = fmt(16'd9, 16'd10);
        check_val("post_valid", 32'(rx_if.oVALID), 32'd1);
        check_val("post_left", 32'(rx_if.oLEFT), 32'(p[31:16]));
        check_val("post_right", 32'(rx_if.oRIGHT), 32'(p[15:0]));
        check_val("post_overrun", 32'(rx_if.oOVERRUN), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
